// File: rtl/pool_pkg.sv
// Shared types, default parameters and helpers for the parallel max/average pooling block.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_WIN_N  = 4;
  localparam int DEF_CH     = 1;

  // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pool_reduce_stage.sv
// One pairwise reduction level: halves the element count per channel and widens each element by one bit.
module pool_reduce_stage
  import pool_pkg::*;
#(
  parameter int CH   = DEF_CH,
  parameter int N_IN = DEF_WIN_N,
  parameter int W_IN = DEF_DATA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              up_valid,
  input  pool_mode_e                        up_mode,
  input  logic [CH*N_IN*W_IN-1:0]           up_data,
  output logic                              dn_valid,
  output pool_mode_e                        dn_mode,
  output logic [CH*(N_IN/2)*(W_IN+1)-1:0]   dn_data
);

  localparam int N_OUT = N_IN / 2;
  localparam int W_OUT = W_IN + 1;

  logic [CH*N_OUT*W_OUT-1:0] nxt;
  logic signed [W_OUT-1:0]   a, b, r;

  // NOTE: a/b/r are scratch values reused per pair, so they take blocking assignments and defaults up front.
  always_comb begin
    nxt = '0;
    a   = '0;
    b   = '0;
    r   = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < N_OUT; k++) begin
        a = {up_data[(c*N_IN+2*k)*W_IN + W_IN-1],   up_data[(c*N_IN+2*k)*W_IN +: W_IN]};
        b = {up_data[(c*N_IN+2*k+1)*W_IN + W_IN-1], up_data[(c*N_IN+2*k+1)*W_IN +: W_IN]};
        if (up_mode == POOL_AVG) r = a + b;
        else                     r = (b > a) ? b : a;  // ties keep the even element
        nxt[(c*N_OUT+k)*W_OUT +: W_OUT] = r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     dn_valid <= 1'b0;
    else if (en) dn_valid <= up_valid;
  end

  // NOTE: payload registers carry no reset; the valid flag alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (en) begin
      dn_mode <= up_mode;
      dn_data <= nxt;
    end
  end

endmodule

// File: rtl/maxpool_par.sv
// Parallel multi-channel max/average pooling pipeline with a single global stall.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative results to zero at the output stage.
module maxpool_par
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN_N  = DEF_WIN_N,
  parameter int CH     = DEF_CH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CH*WIN_N*DATA_W-1:0] i_data,
  input  logic                      i_valid,
  input  logic                      i_mode,
  output logic                      i_ready,
  output logic [CH*DATA_W-1:0]      o_data,
  output logic                      o_valid,
  input  logic                      o_ready
);

  localparam int L = clog2(WIN_N);

  if (WIN_N < 2 || WIN_N > 16 || (WIN_N & (WIN_N - 1)) != 0) begin : g_bad_win_n
    $error("maxpool_par: WIN_N must be a power of two in 2..16");
  end
  if (CH < 1 || CH > 8) begin : g_bad_ch
    $error("maxpool_par: CH must be in 1..8");
  end

  // Every stage advances together, so a stalled output freezes the whole pipe.
  logic en;
  assign i_ready = !o_valid || o_ready;
  assign en      = i_ready;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int N_IN = WIN_N >> s;
    localparam int W_IN = DATA_W + s;

    logic [CH*N_IN*W_IN-1:0]           d_in;
    logic [CH*(N_IN/2)*(W_IN+1)-1:0]   d_out;
    logic                              v_in, v_out;
    pool_mode_e                        m_in, m_out;

    if (s == 0) begin : g_first
      assign d_in = i_data;
      assign v_in = i_valid;
      assign m_in = pool_mode_e'(i_mode);
    end else begin : g_next
      assign d_in = g_stage[s-1].d_out;
      assign v_in = g_stage[s-1].v_out;
      assign m_in = g_stage[s-1].m_out;
    end

    pool_reduce_stage #(
      .CH   (CH),
      .N_IN (N_IN),
      .W_IN (W_IN)
    ) u_stage (
      .clk      (i_clk),
      .rst      (i_rst),
      .en       (en),
      .up_valid (v_in),
      .up_mode  (m_in),
      .up_data  (d_in),
      .dn_valid (v_out),
      .dn_mode  (m_out),
      .dn_data  (d_out)
    );
  end

  logic [CH*(DATA_W+L)-1:0] last_data;
  logic                     last_valid;
  pool_mode_e               last_mode;

  assign last_data  = g_stage[L-1].d_out;
  assign last_valid = g_stage[L-1].v_out;
  assign last_mode  = g_stage[L-1].m_out;

  logic [CH*DATA_W-1:0]   res;
  logic [DATA_W+L-1:0]    sum;
  logic [DATA_W-1:0]      val;

  // Average: keeping bits [L +: DATA_W] is an arithmetic shift by L followed by truncation.
  always_comb begin
    res = '0;
    sum = '0;
    val = '0;
    for (int c = 0; c < CH; c++) begin
      sum = last_data[c*(DATA_W+L) +: DATA_W+L];
      val = (last_mode == POOL_AVG) ? sum[L +: DATA_W] : sum[DATA_W-1:0];
`ifdef MAXPOOL_RELU_EN
      if (val[DATA_W-1]) val = '0;
`endif
      res[c*DATA_W +: DATA_W] = val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (en) begin
      o_valid <= last_valid;
      if (last_valid) o_data <= res;
    end
  end

endmodule

// File: tb/tb_maxpool_par.sv
// Self-checking bench for maxpool_par: directed corner cases plus randomized traffic against a queue-based model.
module tb_maxpool_par;

  localparam int DW  = 24;
  localparam int WN  = 4;
  localparam int CHN = 2;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic [CHN*WN*DW-1:0]   i_data;
  logic                   i_valid;
  logic                   i_mode;
  logic                   i_ready;
  logic [CHN*DW-1:0]      o_data;
  logic                   o_valid;
  logic                   o_ready;

  maxpool_par #(.DATA_W(DW), .WIN_N(WN), .CH(CHN)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_mode  (i_mode),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;
  logic            accepted;
  logic [CHN*DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic over each channel's window.
  function automatic logic [CHN*DW-1:0] model(input logic [CHN*WN*DW-1:0] d, input logic m);
    logic [CHN*DW-1:0] out;
    logic signed [DW-1:0] x;
    int best, sum, r;
    out = '0;
    for (int c = 0; c < CHN; c++) begin
      sum = 0;
      best = 0;
      for (int e = 0; e < WN; e++) begin
        x = d[(c*WN+e)*DW +: DW];
        sum += int'(x);
        if (e == 0 || int'(x) > best) best = int'(x);
      end
      r = m ? (sum >>> $clog2(WN)) : best;
`ifdef MAXPOOL_RELU_EN
      if (r < 0) r = 0;
`endif
      out[c*DW +: DW] = r[DW-1:0];
    end
    return out;
  endfunction

  // One clock: evaluate handshakes before the edge, verify hold behaviour after it.
  task automatic cycle();
    logic stalled;
    logic [CHN*DW-1:0] held;
    #1;
    accepted = 1'b0;
    check("ready_rule", {63'd0, i_ready}, {63'd0, (!o_valid || o_ready)});
    if (i_rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (o_valid && o_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
        else check("out_data", {16'd0, o_data}, {16'd0, exp_q.pop_front()});
      end
      stalled = o_valid && !o_ready;
      held    = o_data;
      if (i_valid && i_ready) begin
        exp_q.push_back(model(i_data, i_mode));
        n_acc++;
        accepted = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    if (stalled) begin
      check("hold_valid", {63'd0, o_valid}, 64'd1);
      check("hold_data", {16'd0, o_data}, {16'd0, held});
    end
    @(negedge i_clk);
  endtask

  function automatic logic [CHN*WN*DW-1:0] rand_data();
    logic [CHN*WN*DW-1:0] d;
    for (int i = 0; i < CHN*WN; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  // Channel 0 gets the directed window, channel 1 gets random data to exercise isolation.
  task automatic send(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                      input logic [DW-1:0] e2, input logic [DW-1:0] e3, input logic m,
                      input logic [DW-1:0] exp0);
    int n;
    i_data = rand_data();
    i_data[0 +: 4*DW] = {e3, e2, e1, e0};
    i_mode  = m;
    i_valid = 1'b1;
    o_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check({tag, "_ch0"}, {40'd0, o_data[DW-1:0]}, {40'd0, exp0});
    cycle();
    check({tag, "_one_cycle"}, {63'd0, o_valid}, 64'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    i_valid = 1'b0;
    o_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || o_valid) && n < 50) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic relu;
  logic [DW-1:0] neg1_or_0, neg2_or_0;

  initial begin
`ifdef MAXPOOL_RELU_EN
    relu = 1'b1;
`else
    relu = 1'b0;
`endif
    neg1_or_0 = relu ? 24'h000000 : 24'hFFFFFF;
    neg2_or_0 = relu ? 24'h000000 : 24'hFFFFFE;

    i_rst = 1'b1; i_valid = 1'b1; i_mode = 1'b0; o_ready = 1'b0; i_data = rand_data();
    @(negedge i_clk);
    cycle();
    cycle();
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_data", {16'd0, o_data}, 64'd0);
    check("rst_i_ready", {63'd0, i_ready}, 64'd1);

    send("max_basic", 24'd5, -24'sd3, 24'd9, 24'd2, 1'b0, 24'd9);
    send("avg_basic", 24'd7, 24'd8, -24'sd1, 24'd2, 1'b1, 24'd4);
    send("avg_floor", -24'sd1, -24'sd1, -24'sd1, 24'd0, 1'b1, neg1_or_0);
    send("max_neg", -24'sd5, -24'sd3, -24'sd9, -24'sd2, 1'b0, neg2_or_0);
    send("max_ext", 24'h800000, 24'h7FFFFF, 24'd0, 24'd0, 1'b0, 24'h7FFFFF);
    send("avg_ext", 24'h800000, 24'h7FFFFF, 24'd0, 24'd0, 1'b1, neg1_or_0);
    send("max_tie", 24'd3, 24'd3, 24'd3, 24'd3, 1'b0, 24'd3);

    // Six back-to-back beats with downstream stalled during cycles 4..7.
    n_acc = 0; n_out = 0;
    begin
      int sent;
      sent = 0;
      for (int i = 0; i < 14; i++) begin
        i_valid = (sent < 6);
        if (i_valid) i_data = rand_data();
        i_mode  = i[0];
        o_ready = !(i >= 4 && i <= 7);
        if (i >= 4 && i <= 7) begin
          #1;
          check("bp_ready_low", {63'd0, i_ready}, 64'd0);
        end
        cycle();
        if (accepted) sent++;
        while (i_valid && !accepted && sent < 6 && i < 13) begin
          i++;
          o_ready = !(i >= 4 && i <= 7);
          cycle();
          if (accepted) sent++;
        end
      end
    end
    drain("bp");
    check("bp_accepted", 64'(n_acc), 64'd6);
    check("bp_delivered", 64'(n_out), 64'd6);

    // Reset while three beats are in flight; i_valid held high through the reset cycle.
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_mode = 1'($urandom); i_data = rand_data();
      cycle();
    end
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0; i_valid = 1'b0;
    check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("midrst_no_stale", {63'd0, o_valid}, 64'd0);
    end
    send("post_rst", 24'd1, 24'd100, -24'sd7, 24'd50, 1'b0, 24'd100);

    // Randomized traffic with mixed modes, bubbles and backpressure.
    n_acc = 0; n_out = 0;
    for (int i = 0; i < 400; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_mode  = 1'($urandom);
      i_data  = rand_data();
      o_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain("rand");
    check("rand_count", 64'(n_out), 64'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
